arcade_input_mapper: RTL and testbench
======================================

# arcade_input_mapper

Registered, parametrised control front-end between `hps_io` and the game `top` for the vector-game family (Battlezone, Bradley, Red Baron). It absorbs per-game mode selection, DIP-switch capture from the download stream, 8-way/dual-stick tank-tread decode, coin pulse shaping and analog-axis conditioning. It replaces the ad-hoc combinational mapping in the core wrapper.

## Interface

**Parameters**
- `DSW_BYTES`, 8 — DIP bytes captured; range 1–8.
- `DSW_INDEX`, 254 — `ioctl_index` carrying DIP data.
- `MOD_INDEX`, 1 — `ioctl_index` carrying the game-mode byte.
- `COIN_PULSE`, 50000 — coin output high-time in `clk_sys` cycles; must be ≥ 1.

**Ports**
- `clk_sys` in 1 — sole clock.
- `reset` in 1 — synchronous, active-high.
- `joy_0`, `joy_1` in 16 each — bit 0 R, 1 L, 2 D, 3 U, 4 fire, 5 start1, 6 start2, 7 coin.
- `joya` in 16 — analog stick; [7:0] X, [15:8] Y, two's complement.
- `adc_sel` in 1 — game-side analog channel select (0 = X, 1 = Y).
- `dual_stick` in 1 — tread mode: 0 = 8-way single stick, 1 = two sticks.
- `ioctl_wr` in 1, `ioctl_index` in 8, `ioctl_addr` in 25, `ioctl_dout` in 8 — download stream.
- `mod` out 8 — captured game id.
- `mod_valid` out 1 — high once a mode byte has been written.
- `dsw` out `8*DSW_BYTES` — DIP bytes, byte n at [8n+7:8n].
- `treads` out 4 — {L_fw, L_bk, R_fw, R_bk}.
- `tank_buttons` out 8 — {2'b00, start1, fire|start2, treads}.
- `flight_buttons` out 8 — {fire, start1, 6'b0}.
- `analog_out` out 8 — conditioned analog value.
- `coin` out 1 — shaped coin pulse.

## Operation

- Stage 1 registers `joy_0|joy_1` (merged), `joy_0`, `joy_1`, `joya` and `adc_sel`.
- Stage 2 registers all decoded outputs.
- **8-way decode** (`dual_stick = 0`, merged stick, code = {U,D,L,R}):
  - 1000 → L_fw, R_fw
  - 1010 → R_fw
  - 1001 → L_fw
  - 0001 → L_fw, R_bk
  - 0101 → L_bk
  - 0100 → L_bk, R_bk
  - 0110 → R_bk
  - 0010 → L_bk, R_fw
  - any other code, including opposing bits → 0000
- **Dual stick** (`dual_stick = 1`):
  - `joy_0` U/D drives L_fw/L_bk; `joy_1` U/D drives R_fw/R_bk.
  - U and D both set on one stick → both bits of that tread 0.
- **Analog:**
  - `analog_out = 8'd127 - axis`, where axis is selected by the registered `adc_sel`.
  - Arithmetic is 8-bit modulo 256: axis 0x80 → 0xFF, axis 0x7F → 0x00.
- **Coin:**
  - A rising edge of stage-1 merged coin while the counter is 0 loads the counter with `COIN_PULSE`.
  - `coin` is high while the counter ≠ 0; the counter decrements each cycle.
  - Edges arriving while the counter ≠ 0 are ignored.
- **Mode byte:**
  - On `ioctl_wr && ioctl_index == MOD_INDEX`, `mod <= ioctl_dout` and `mod_valid <= 1`.
  - The last write wins.
- **DIP capture:**
  - On `ioctl_wr && ioctl_index == DSW_INDEX && ioctl_addr[24:3] == 0 && ioctl_addr[2:0] < DSW_BYTES`, byte `ioctl_addr[2:0]` is written.
  - Any other address is dropped.

## Timing

- Latency from `joy`/`joya`/`adc_sel` to `treads`, buttons and `analog_out` is 2 cycles.
- `coin` rises 2 cycles after the input rising edge and stays high exactly `COIN_PULSE` cycles.
- `mod`/`dsw` update 1 cycle after the qualifying `ioctl_wr`. `mod_valid` rises in the same cycle as that `mod` update.
- **Reset** clears the pipeline registers, `treads`, `tank_buttons`, `flight_buttons`, `analog_out`, `coin`, the coin counter and the edge-detect history; all of these read 0.
- Reset does **not** touch `mod`, `mod_valid` or `dsw`, because the core reset spans downloads.
  - Power-up values: `mod` = 8'hFF, `mod_valid` = 0, `dsw` = 0.
  - A download write concurrent with `reset` is still captured.
- Reset during a coin pulse terminates it next cycle. A coin held high across reset release produces no pulse until it falls and rises again.

## Structure

- Shared package `arcade_input_pkg` holds:
  - joystick bit-index constants;
  - `MOD_BATTLEZONE` = 0, `MOD_BRADLEY` = 1, `MOD_REDBARON` = 2;
  - the `treads_t` packed struct.
- One sub-module, `tread_decode`: purely combinational, inputs {U,D,L,R} ×2 plus `dual_stick`, output 4-bit treads. It is instanced once before the stage-2 registers.
- The coin shaper, DIP capture and analog conditioning stay inline.

## Test plan

- `joy_0` = 0x0008 (Up), `dual_stick` = 0 → `treads` = 1010 and `tank_buttons` = 0x0A after 2 cycles; 0x000C → 0000.
- `dual_stick` = 1, `joy_0` = 0x0008, `joy_1` = 0x0004 → `treads` = 1001.
- `joya` = 0x8040, `adc_sel` 0 then 1 → `analog_out` 0x3F then 0xFF.
- `COIN_PULSE` = 4: coin held 10 cycles → `coin` high exactly 4 cycles. A second edge at pulse cycle 2 is ignored; an edge after the pulse fires again.
- `ioctl` index 254, addr 0..9, data 0xA0+addr with `DSW_BYTES` = 8 → `dsw` bytes 0xA0..0xA7; addr 8, 9 dropped. Index 1, data 0x02 → `mod` = 2, `mod_valid` = 1.
- Assert `reset` mid-coin-pulse and during a DIP write → `coin` 0 next cycle, the DIP byte is still written, `mod` is unchanged.

Source files
------------

// File: rtl/arcade_input_mapper_pkg.sv
// Shared definitions for the vector-game input front-end: joystick bit
// positions, game ids and the tread output layout.
package arcade_input_pkg;

    localparam int JOY_R      = 0;
    localparam int JOY_L      = 1;
    localparam int JOY_D      = 2;
    localparam int JOY_U      = 3;
    localparam int JOY_FIRE   = 4;
    localparam int JOY_START1 = 5;
    localparam int JOY_START2 = 6;
    localparam int JOY_COIN   = 7;

    localparam logic [7:0] MOD_BATTLEZONE = 8'd0;
    localparam logic [7:0] MOD_BRADLEY    = 8'd1;
    localparam logic [7:0] MOD_REDBARON   = 8'd2;

    typedef struct packed {
        logic l_fw;
        logic l_bk;
        logic r_fw;
        logic r_bk;
    } treads_t;

endpackage

// File: rtl/arcade_input_mapper_if.sv
// Download stream from hps_io: the mapper only ever listens (slave side).
interface arcade_input_mapper_if;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    modport master (output ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout);
    modport slave  (input  ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout);
endinterface

// File: rtl/arcade_input_mapper_tread_decode.sv
// Combinational tank-tread decode from one or two {U,D,L,R} sticks.
module tread_decode
    import arcade_input_pkg::*;
(
    input  logic [3:0] stick0_i,
    input  logic [3:0] stick1_i,
    input  logic       dual_stick_i,
    output treads_t    treads_o
);
    logic [3:0] merged;

    always_comb begin
        treads_o = '0;
        merged   = stick0_i | stick1_i;
        if (dual_stick_i) begin
            treads_o.l_fw = stick0_i[3] & ~stick0_i[2];
            treads_o.l_bk = stick0_i[2] & ~stick0_i[3];
            treads_o.r_fw = stick1_i[3] & ~stick1_i[2];
            treads_o.r_bk = stick1_i[2] & ~stick1_i[3];
        end else begin
            // Reversing diagonals steer like a backing vehicle: the outer tread drives.
            case (merged)
                4'b1000: treads_o = 4'b1010;
                4'b1010: treads_o = 4'b0010;
                4'b1001: treads_o = 4'b1000;
                4'b0001: treads_o = 4'b1001;
                4'b0101: treads_o = 4'b0100;
                4'b0100: treads_o = 4'b0101;
                4'b0110: treads_o = 4'b0001;
                4'b0010: treads_o = 4'b0110;
                default: treads_o = 4'b0000;
            endcase
        end
    end

endmodule

// File: rtl/arcade_input_mapper.sv
// Registered control front-end between hps_io and the vector-game top:
// mode/DIP capture, tread decode, coin pulse shaping and analog conditioning.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int DSW_BYTES  = 8,
    parameter int DSW_INDEX  = 254,
    parameter int MOD_INDEX  = 1,
    parameter int COIN_PULSE = 50000
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic [15:0]            joy_0,
    input  logic [15:0]            joy_1,
    input  logic [15:0]            joya,
    input  logic                   adc_sel,
    input  logic                   dual_stick,
    arcade_input_mapper_if.slave   ioctl,
    output logic [7:0]             mod,
    output logic                   mod_valid,
    output logic [8*DSW_BYTES-1:0] dsw,
    output logic [3:0]             treads,
    output logic [7:0]             tank_buttons,
    output logic [7:0]             flight_buttons,
    output logic [7:0]             analog_out,
    output logic                   coin
);
    localparam int CNT_W = $clog2(COIN_PULSE + 1);

    logic             unused_joy_hi;
    assign unused_joy_hi = ^{joy_0[15:8], joy_1[15:8]};

    logic [7:4]  btn_q;
    logic [3:0]  stick0_q, stick1_q;
    logic [15:0] joya_q;
    logic        adc_sel_q, dual_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            btn_q     <= '0;
            stick0_q  <= '0;
            stick1_q  <= '0;
            joya_q    <= '0;
            adc_sel_q <= 1'b0;
            dual_q    <= 1'b0;
        end else begin
            btn_q     <= joy_0[7:4] | joy_1[7:4];
            stick0_q  <= joy_0[3:0];
            stick1_q  <= joy_1[3:0];
            joya_q    <= joya;
            adc_sel_q <= adc_sel;
            dual_q    <= dual_stick;
        end
    end

    treads_t    treads_d;
    logic [7:0] axis, analog_d, tank_d, flight_d;
    logic [3:0] treads_q;
    logic [7:0] tank_q, flight_q, analog_q;

    tread_decode u_tread_decode (
        .stick0_i     (stick0_q),
        .stick1_i     (stick1_q),
        .dual_stick_i (dual_q),
        .treads_o     (treads_d)
    );

    always_comb begin
        axis     = adc_sel_q ? joya_q[15:8] : joya_q[7:0];
        analog_d = 8'd127 - axis;
        tank_d   = {2'b00, btn_q[JOY_START1], btn_q[JOY_FIRE] | btn_q[JOY_START2], treads_d};
        flight_d = {btn_q[JOY_FIRE], btn_q[JOY_START1], 6'b000000};
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            treads_q <= '0;
            tank_q   <= '0;
            flight_q <= '0;
            analog_q <= '0;
        end else begin
            treads_q <= treads_d;
            tank_q   <= tank_d;
            flight_q <= flight_d;
            analog_q <= analog_d;
        end
    end

    assign treads         = treads_q;
    assign tank_buttons   = tank_q;
    assign flight_buttons = flight_q;
    assign analog_out     = analog_q;

    // The armed flag only sets once the raw coin has been seen low, so a coin
    // held through reset release cannot masquerade as a fresh insertion.
    logic [CNT_W-1:0] coin_cnt_q, coin_cnt_d;
    logic             coin_prev_q, coin_armed_q, coin_armed_d, coin_rise;

    always_comb begin
        coin_rise    = btn_q[JOY_COIN] & ~coin_prev_q & coin_armed_q;
        coin_armed_d = coin_armed_q | ~(joy_0[JOY_COIN] | joy_1[JOY_COIN]);
        coin_cnt_d   = coin_cnt_q;
        if (coin_cnt_q != '0) begin
            coin_cnt_d = coin_cnt_q - CNT_W'(1);
        end else if (coin_rise) begin
            coin_cnt_d = CNT_W'(COIN_PULSE);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            coin_cnt_q   <= '0;
            coin_prev_q  <= 1'b0;
            coin_armed_q <= 1'b0;
        end else begin
            coin_cnt_q   <= coin_cnt_d;
            coin_prev_q  <= btn_q[JOY_COIN];
            coin_armed_q <= coin_armed_d;
        end
    end

    assign coin = (coin_cnt_q != '0);

    // Download-side state survives core reset; the core is reset around downloads.
    logic [7:0] mod_q       = 8'hFF;
    logic       mod_valid_q = 1'b0;

    always_ff @(posedge clk_sys) begin
        if (ioctl.ioctl_wr && ioctl.ioctl_index == 8'(MOD_INDEX)) begin
            mod_q       <= ioctl.ioctl_dout;
            mod_valid_q <= 1'b1;
        end
    end

    assign mod       = mod_q;
    assign mod_valid = mod_valid_q;

    logic dsw_region;
    assign dsw_region = ioctl.ioctl_wr && (ioctl.ioctl_index == 8'(DSW_INDEX))
                        && (ioctl.ioctl_addr[24:3] == '0);

    for (genvar gi = 0; gi < DSW_BYTES; gi++) begin : g_dsw
        logic [7:0] byte_q = 8'h00;

        always_ff @(posedge clk_sys) begin
            if (dsw_region && ioctl.ioctl_addr[2:0] == 3'(gi)) begin
                byte_q <= ioctl.ioctl_dout;
            end
        end

        assign dsw[8*gi +: 8] = byte_q;
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Self-checking bench: vector table, randomized run against a tread/analog
// model, and hand sequences for coin shaping, downloads and reset.
module tb_arcade_input_mapper;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [15:0] joy_0   = '0;
    logic [15:0] joy_1   = '0;
    logic [15:0] joya    = '0;
    logic        adc_sel = 1'b0;
    logic        dual_stick = 1'b0;

    logic [7:0]  mod;
    logic        mod_valid;
    logic [63:0] dsw;
    logic [3:0]  treads;
    logic [7:0]  tank_buttons, flight_buttons, analog_out;
    logic        coin;

    int checks = 0;
    int errors = 0;

    arcade_input_mapper_if ioctl_bus ();

    arcade_input_mapper #(
        .DSW_BYTES  (8),
        .DSW_INDEX  (254),
        .MOD_INDEX  (1),
        .COIN_PULSE (4)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .joy_0          (joy_0),
        .joy_1          (joy_1),
        .joya           (joya),
        .adc_sel        (adc_sel),
        .dual_stick     (dual_stick),
        .ioctl          (ioctl_bus),
        .mod            (mod),
        .mod_valid      (mod_valid),
        .dsw            (dsw),
        .treads         (treads),
        .tank_buttons   (tank_buttons),
        .flight_buttons (flight_buttons),
        .analog_out     (analog_out),
        .coin           (coin)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [15:0] j0;
        logic [15:0] j1;
        logic [15:0] ja;
        logic        sel;
        logic        dual;
        logic [3:0]  tr;
        logic [7:0]  tank;
        logic [7:0]  flight;
        logic [7:0]  an;
    } vec_t;

    typedef struct {
        logic [3:0] tr;
        logic [7:0] tank;
        logic [7:0] flight;
        logic [7:0] an;
    } exp_t;

    vec_t vecs [14];
    exp_t exp_q [$];

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic ioctl_write(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
        ioctl_bus.ioctl_wr    = 1'b1;
        ioctl_bus.ioctl_index = idx;
        ioctl_bus.ioctl_addr  = addr;
        ioctl_bus.ioctl_dout  = data;
        step();
        ioctl_bus.ioctl_wr    = 1'b0;
        $display("ioctl idx=%0d addr=0x%0h data=0x%02h -> mod=0x%02h dsw=0x%016h",
                 idx, addr, data, mod, dsw);
    endtask

    // Treads from a steering view: forward/turn components mixed into left/right
    // tread speeds, with steering mirrored while reversing.
    function automatic logic [3:0] model_treads(input logic [3:0] a, input logic [3:0] b,
                                                input logic dual);
        int l, r, fwd, turn;
        logic [3:0] m;
        if (dual) begin
            l = int'(a[3]) - int'(a[2]);
            r = int'(b[3]) - int'(b[2]);
        end else begin
            m = a | b;
            if ((m[3] && m[2]) || (m[1] && m[0])) return 4'b0000;
            fwd  = int'(m[3]) - int'(m[2]);
            turn = int'(m[0]) - int'(m[1]);
            if (fwd >= 0) begin
                l = fwd + turn;
                r = fwd - turn;
            end else begin
                l = fwd - turn;
                r = fwd + turn;
            end
        end
        return {l > 0, l < 0, r > 0, r < 0};
    endfunction

    function automatic exp_t model(input logic [15:0] j0, input logic [15:0] j1,
                                   input logic [15:0] ja, input logic sel, input logic dual);
        exp_t e;
        logic [15:0] m;
        int axis;
        m = j0 | j1;
        e.tr     = model_treads(j0[3:0], j1[3:0], dual);
        e.tank   = {2'b00, m[5], m[4] | m[6], e.tr};
        e.flight = {m[4], m[5], 6'b000000};
        axis     = sel ? int'(ja[15:8]) : int'(ja[7:0]);
        e.an     = 8'((127 - axis) & 255);
        return e;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        exp_t e;
        logic [7:0] data;

        ioctl_bus.ioctl_wr    = 1'b0;
        ioctl_bus.ioctl_index = '0;
        ioctl_bus.ioctl_addr  = '0;
        ioctl_bus.ioctl_dout  = '0;

        vecs[0]  = '{16'h0008, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'b1010, 8'h0A, 8'h00, 8'h7F};
        vecs[1]  = '{16'h000C, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'b0000, 8'h00, 8'h00, 8'h7F};
        vecs[2]  = '{16'h0008, 16'h0004, 16'h0000, 1'b0, 1'b1, 4'b1001, 8'h09, 8'h00, 8'h7F};
        vecs[3]  = '{16'h0000, 16'h0000, 16'h8040, 1'b0, 1'b0, 4'b0000, 8'h00, 8'h00, 8'h3F};
        vecs[4]  = '{16'h0000, 16'h0000, 16'h8040, 1'b1, 1'b0, 4'b0000, 8'h00, 8'h00, 8'hFF};
        vecs[5]  = '{16'h0000, 16'h0000, 16'h007F, 1'b0, 1'b0, 4'b0000, 8'h00, 8'h00, 8'h00};
        vecs[6]  = '{16'h000A, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'b0010, 8'h02, 8'h00, 8'h7F};
        vecs[7]  = '{16'h0001, 16'h0004, 16'h0000, 1'b0, 1'b0, 4'b0100, 8'h04, 8'h00, 8'h7F};
        vecs[8]  = '{16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'b0000, 8'h10, 8'h80, 8'h7F};
        vecs[9]  = '{16'h0000, 16'h0020, 16'h0000, 1'b0, 1'b0, 4'b0000, 8'h20, 8'h40, 8'h7F};
        vecs[10] = '{16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'b0000, 8'h10, 8'h00, 8'h7F};
        vecs[11] = '{16'h000C, 16'h0008, 16'h0000, 1'b0, 1'b1, 4'b0010, 8'h02, 8'h00, 8'h7F};
        vecs[12] = '{16'h0004, 16'h0004, 16'h0000, 1'b0, 1'b1, 4'b0101, 8'h05, 8'h00, 8'h7F};
        vecs[13] = '{16'h0000, 16'h0006, 16'h0000, 1'b0, 1'b0, 4'b0001, 8'h01, 8'h00, 8'h7F};

        #1;
        check("pwr_mod", mod, 8'hFF);
        check("pwr_mod_valid", mod_valid, 1'b0);
        check("pwr_dsw", dsw, 64'h0);

        // Live inputs during reset: outputs must still read zero.
        joy_0 = 16'h0018;
        repeat (3) step();
        $display("reset: treads=%b tank=0x%02h flight=0x%02h analog=0x%02h coin=%b",
                 treads, tank_buttons, flight_buttons, analog_out, coin);
        check("rst_treads", treads, 4'h0);
        check("rst_tank", tank_buttons, 8'h00);
        check("rst_flight", flight_buttons, 8'h00);
        check("rst_analog", analog_out, 8'h00);
        check("rst_coin", coin, 1'b0);
        reset = 1'b0;
        joy_0 = '0;
        step();

        for (int i = 0; i < 14; i++) begin
            joy_0 = vecs[i].j0;
            joy_1 = vecs[i].j1;
            joya  = vecs[i].ja;
            adc_sel    = vecs[i].sel;
            dual_stick = vecs[i].dual;
            step();
            step();
            $display("vec %0d: j0=0x%04h j1=0x%04h ja=0x%04h sel=%b dual=%b -> treads=%b tank=0x%02h flight=0x%02h analog=0x%02h",
                     i, joy_0, joy_1, joya, adc_sel, dual_stick, treads, tank_buttons,
                     flight_buttons, analog_out);
            check($sformatf("vec%0d_treads", i), treads, vecs[i].tr);
            check($sformatf("vec%0d_tank", i), tank_buttons, vecs[i].tank);
            check($sformatf("vec%0d_flight", i), flight_buttons, vecs[i].flight);
            check($sformatf("vec%0d_analog", i), analog_out, vecs[i].an);
        end

        for (int i = 0; i < 200; i++) begin
            joy_0 = 16'($urandom) & 16'hFF7F;
            joy_1 = 16'($urandom) & 16'hFF7F;
            joya  = 16'($urandom);
            adc_sel    = 1'($urandom);
            dual_stick = 1'($urandom);
            exp_q.push_back(model(joy_0, joy_1, joya, adc_sel, dual_stick));
            step();
            if (exp_q.size() >= 2) begin
                e = exp_q.pop_front();
                check("rnd_treads", treads, e.tr);
                check("rnd_tank", tank_buttons, e.tank);
                check("rnd_flight", flight_buttons, e.flight);
                check("rnd_analog", analog_out, e.an);
            end
        end
        joy_0 = '0;
        joy_1 = '0;
        dual_stick = 1'b0;
        repeat (3) step();

        check("mod_valid_before", mod_valid, 1'b0);
        for (int a = 0; a < 10; a++) begin
            data = 8'hA0 + 8'(a);
            ioctl_write(8'd254, 25'(a), data);
            if (a < 8) check($sformatf("dsw_byte%0d", a), dsw[8*a +: 8], data);
        end
        check("dsw_all", dsw, 64'hA7A6_A5A4_A3A2_A1A0);
        ioctl_write(8'd253, 25'd0, 8'h11);
        check("dsw_wrong_index", dsw[7:0], 8'hA0);
        ioctl_write(8'd254, 25'h100002, 8'h77);
        check("dsw_high_addr", dsw[23:16], 8'hA2);
        check("mod_untouched", mod, 8'hFF);
        ioctl_write(8'd1, 25'd0, 8'h05);
        check("mod_first", mod, 8'h05);
        check("mod_valid", mod_valid, 1'b1);
        ioctl_write(8'd1, 25'd0, 8'h02);
        check("mod_last_wins", mod, 8'h02);

        // Coin held 10 cycles: 2-cycle rise latency, exactly 4 cycles high.
        hi = 0;
        joy_0 = 16'h0080;
        for (int i = 0; i < 14; i++) begin
            if (i == 10) joy_0 = '0;
            step();
            if (i == 0) check("coin_lat1", coin, 1'b0);
            if (i == 1) check("coin_lat2", coin, 1'b1);
            hi += int'(coin);
        end
        $display("coin held 10: high cycles=%0d", hi);
        check("coin_width", hi, 4);

        // Second edge inside the pulse must be ignored.
        hi = 0;
        for (int i = 0; i < 14; i++) begin
            joy_0 = (i < 2 || (i >= 3 && i < 8)) ? 16'h0080 : 16'h0000;
            step();
            hi += int'(coin);
        end
        $display("coin re-edge in pulse: high cycles=%0d", hi);
        check("coin_ignore_edge", hi, 4);

        joy_1 = 16'h0080;
        step();
        step();
        $display("coin refire: coin=%b", coin);
        check("coin_refire", coin, 1'b1);
        repeat (6) step();

        // Coin held across reset release must not fire until re-pressed.
        reset = 1'b1;
        step();
        step();
        check("coin_in_reset", coin, 1'b0);
        reset = 1'b0;
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            hi += int'(coin);
        end
        $display("coin held across reset: high cycles=%0d", hi);
        check("coin_held_reset", hi, 0);
        joy_1 = '0;
        step();
        step();
        joy_1 = 16'h0080;
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            hi += int'(coin);
        end
        $display("coin after re-press: high cycles=%0d", hi);
        check("coin_repress", hi, 4);
        joy_1 = '0;
        repeat (3) step();

        // Reset mid-pulse with a concurrent DIP write.
        joy_0 = 16'h0080;
        step();
        step();
        check("coin_pre_reset", coin, 1'b1);
        reset = 1'b1;
        ioctl_bus.ioctl_wr    = 1'b1;
        ioctl_bus.ioctl_index = 8'd254;
        ioctl_bus.ioctl_addr  = 25'd3;
        ioctl_bus.ioctl_dout  = 8'h5A;
        step();
        ioctl_bus.ioctl_wr = 1'b0;
        $display("reset mid-pulse: coin=%b dsw=0x%016h mod=0x%02h", coin, dsw, mod);
        check("coin_reset_cut", coin, 1'b0);
        check("dsw_during_reset", dsw[31:24], 8'h5A);
        check("mod_across_reset", mod, 8'h02);
        check("mod_valid_across_reset", mod_valid, 1'b1);
        reset = 1'b0;
        joy_0 = '0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
